alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu_core.sv | 33 +++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: definitions shared by the two-requester ALU arbiter.
//   OP_NOT/OP_AND/OP_OR/OP_ADD : 2-bit opcode values
//   state_e                    : arbiter FSM state type (IDLE=0, EXEC=1, RESP=2)
package alu_arb_pkg;

  localparam logic [1:0] OP_NOT = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU shared by both requesters.
//   op    in  : opcode (OP_NOT, OP_AND, OP_OR, OP_ADD)
//   a, b  in  : operands
//   data  out : result
//   carry out : carry-out, only non-zero for OP_ADD
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] data,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    data  = '0;
    carry = 1'b0;
    case (op)
      OP_NOT: data = ~b;
      OP_AND: data = a & b;
      OP_OR:  data = a | b;
      OP_ADD: {carry, data} = sum;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter letting two requesters share one ALU.
// One operation is in flight at a time: accept (IDLE) -> compute (EXEC)
// -> hold the response until the granted requester takes it (RESP).
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid / req_ready [1:0] : per-requester request handshake
//   req_op0/1, req_a0/1, req_b0/1 : opcode and operands per requester
//   rsp_valid / rsp_ready [1:0] : per-requester response handshake (one-hot valid)
//   rsp_data, rsp_carry         : shared result bus, holds last result
//   busy                        : high whenever the FSM is not IDLE
//   grant_cnt0/1                : saturating acceptance counters, present only
//                                 when ALU_ARB_PERF_EN is defined
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no operation in flight, offering req_ready to the grantee
// EXEC  | operands latched, ALU result registered at the end of cycle
// RESP  | rsp_valid to grantee, waiting for its rsp_ready
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;

  logic              sel;
  logic              accept;
  logic [DATA_W-1:0] alu_data;
  logic              alu_carry;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .data  (alu_data),
    .carry (alu_carry)
  );

  // On a tie the requester that was not granted last time wins; otherwise
  // the single valid requester wins. rst_n gates ready so nothing can be
  // handed over while reset is asserted.
  always_comb begin
    sel       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    accept    = rst_n && (state_q == IDLE) && (req_valid != 2'b00);
    req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          gnt_d   = sel;
          last_d  = sel;
          op_d    = sel ? req_op1 : req_op0;
          a_d     = sel ? req_a1  : req_a0;
          b_d     = sel ? req_b1  : req_b0;
        end
      end
      EXEC: begin
        data_d  = alu_data;
        carry_d = alu_carry;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !sel && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (accept &&  sel && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
